// File: rtl/pc_fetch_controller_if.sv
// Purpose: fetch-side bundle between the PC fetch controller, instruction memory and decode.
// Latency: none (wires only); all timing is owned by the controller behind the master modport.
// Backpressure: decode holds the controller with stall; memory completes a request with imem_ack.
//
// Signals:
//   stall, jump, jump_target, branch_taken, branch_target : decode/redirect controls into fetch
//   imem_req, imem_addr / imem_ack, imem_rdata            : instruction memory request/acknowledge
//   instr_out, instr_valid, pc_out                        : instruction presented to decode
//   invalid_pc, fetch_timeout, fault_pc                   : sticky fault report
interface pc_fetch_controller_if;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [12:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        invalid_pc;
    logic        fetch_timeout;
    logic [31:0] fault_pc;

    // Fetch controller side.
    modport master (
        input  stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_out, instr_valid, pc_out, invalid_pc, fetch_timeout, fault_pc
    );

    // Memory / decode / environment side.
    modport slave (
        output stall, jump, jump_target, branch_taken, branch_target, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_out, instr_valid, pc_out, invalid_pc, fetch_timeout, fault_pc
    );
endinterface

// File: rtl/pc_fetch_controller.sv
// Purpose: owns the virtual PC, fetches one instruction at a time from imem and traps bad fetches.
// Latency: 3 cycles/instruction minimum (FETCH check, WAIT with ack, HOLD presenting to decode).
// Backpressure: stall keeps HOLD and the presented instruction stable; no ack within TIMEOUT faults.
//
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   fetchBus : pc_fetch_controller_if.master (redirects, imem handshake, decode output, fault flags)
module pc_fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] TEXT_BASE  = 32'h0040_0000,
    parameter logic [31:0] TEXT_LIMIT = 32'h0040_1FFF,
    parameter int          TIMEOUT    = 16               // 1..255 WAIT cycles
) (
    input  logic                   clk,
    input  logic                   rst,
    pc_fetch_controller_if.master  fetchBus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } stateT;

    // The low 13 bits of (pc - TEXT_BASE) depend only on the low 13 bits of each operand.
    localparam logic [12:0] BASE_LOW   = TEXT_BASE[12:0];
    localparam logic [7:0]  TIMER_LAST = 8'(TIMEOUT - 1);

    stateT       state, stateNext;
    logic [31:0] pc, pcNext;
    logic [7:0]  timer, timerNext;
    logic [31:0] instrOut, instrOutNext;
    logic [31:0] pcOut, pcOutNext;
    logic        instrValid, instrValidNext;
    logic        invalidPc, invalidPcNext;
    logic        fetchTimeout, fetchTimeoutNext;
    logic [31:0] faultPc, faultPcNext;
    logic        pcBad;

    assign pcBad = (pc < TEXT_BASE) || (pc > TEXT_LIMIT) || (pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            timer        <= 8'd0;
            instrOut     <= 32'd0;
            pcOut        <= 32'd0;
            instrValid   <= 1'b0;
            invalidPc    <= 1'b0;
            fetchTimeout <= 1'b0;
            faultPc      <= 32'd0;
        end else begin
            state        <= stateNext;
            pc           <= pcNext;
            timer        <= timerNext;
            instrOut     <= instrOutNext;
            pcOut        <= pcOutNext;
            instrValid   <= instrValidNext;
            invalidPc    <= invalidPcNext;
            fetchTimeout <= fetchTimeoutNext;
            faultPc      <= faultPcNext;
        end
    end

    always_comb begin
        stateNext        = state;
        pcNext           = pc;
        timerNext        = timer;
        instrOutNext     = instrOut;
        pcOutNext        = pcOut;
        instrValidNext   = instrValid;
        invalidPcNext    = invalidPc;
        fetchTimeoutNext = fetchTimeout;
        faultPcNext      = faultPc;

        case (state)
            FETCH: begin
                if (pcBad) begin
                    stateNext     = FAULT;
                    invalidPcNext = 1'b1;
                    faultPcNext   = pc;
                end else begin
                    stateNext = WAIT;
                    timerNext = 8'd0;
                end
            end
            WAIT: begin
                // An ack on the last allowed cycle still completes the fetch.
                if (fetchBus.imem_ack) begin
                    instrOutNext   = fetchBus.imem_rdata;
                    pcOutNext      = pc;
                    instrValidNext = 1'b1;
                    stateNext      = HOLD;
                end else if (timer == TIMER_LAST) begin
                    stateNext        = FAULT;
                    fetchTimeoutNext = 1'b1;
                    faultPcNext      = pc;
                end else begin
                    timerNext = timer + 8'd1;
                end
            end
            HOLD: begin
                // Redirects are only honoured on the cycle decode accepts the instruction.
                if (!fetchBus.stall) begin
                    if (fetchBus.jump) begin
                        pcNext = fetchBus.jump_target;
                    end else if (fetchBus.branch_taken) begin
                        pcNext = fetchBus.branch_target;
                    end else begin
                        pcNext = pc + 32'd4;
                    end
                    instrValidNext = 1'b0;
                    stateNext      = FETCH;
                end
            end
            FAULT: begin
                // Terminal until reset; flags and fault_pc stay as captured.
                instrValidNext = 1'b0;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign fetchBus.imem_req      = (state == WAIT);
    assign fetchBus.imem_addr     = (state == WAIT) ? (pc[12:0] - BASE_LOW) : 13'd0;
    assign fetchBus.instr_out     = instrOut;
    assign fetchBus.instr_valid   = instrValid;
    assign fetchBus.pc_out        = pcOut;
    assign fetchBus.invalid_pc    = invalidPc;
    assign fetchBus.fetch_timeout = fetchTimeout;
    assign fetchBus.fault_pc      = faultPc;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Purpose: directed self-checking bench for pc_fetch_controller (fetch, stall, redirects, faults).
// Latency: inputs change #1 after a rising edge; outputs are sampled at that same point.
// Backpressure: memory ack and decode stall are driven step by step from one initial block.
module tb_pc_fetch_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_fetch_controller_if fetchBus ();

    pc_fetch_controller #(
        .RESET_PC   (32'h0040_0000),
        .TEXT_BASE  (32'h0040_0000),
        .TEXT_LIMIT (32'h0040_1FFF),
        .TIMEOUT    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fetchBus (fetchBus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Bounded wait for the next memory request.
    task automatic waitReq(input string tag);
        for (int i = 0; i < 4 && fetchBus.imem_req !== 1'b1; i++) tick();
        check({tag, "_req"}, {31'd0, fetchBus.imem_req}, 32'd1);
    endtask

    task automatic ackWith(input logic [31:0] data);
        fetchBus.imem_ack   = 1'b1;
        fetchBus.imem_rdata = data;
        tick();
        fetchBus.imem_ack   = 1'b0;
        fetchBus.imem_rdata = 32'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        fetchBus.stall         = 1'b0;
        fetchBus.jump          = 1'b0;
        fetchBus.jump_target   = 32'd0;
        fetchBus.branch_taken  = 1'b0;
        fetchBus.branch_target = 32'd0;
        fetchBus.imem_ack      = 1'b0;
        fetchBus.imem_rdata    = 32'd0;

        // Reset state.
        tick();
        tick();
        check("rst_req",     {31'd0, fetchBus.imem_req}, 32'd0);
        check("rst_addr",    {19'd0, fetchBus.imem_addr}, 32'd0);
        check("rst_instr",   fetchBus.instr_out, 32'd0);
        check("rst_valid",   {31'd0, fetchBus.instr_valid}, 32'd0);
        check("rst_pcout",   fetchBus.pc_out, 32'd0);
        check("rst_inv",     {31'd0, fetchBus.invalid_pc}, 32'd0);
        check("rst_tmo",     {31'd0, fetchBus.fetch_timeout}, 32'd0);
        check("rst_faultpc", fetchBus.fault_pc, 32'd0);

        // First fetch: FETCH, WAIT (acked), HOLD on cycle 3.
        rst = 1'b0;
        tick();
        check("f0_req",  {31'd0, fetchBus.imem_req}, 32'd1);
        check("f0_addr", {19'd0, fetchBus.imem_addr}, 32'd0);
        ackWith(32'h2008_000A);
        check("f0_valid", {31'd0, fetchBus.instr_valid}, 32'd1);
        check("f0_pcout", fetchBus.pc_out, 32'h0040_0000);
        check("f0_instr", fetchBus.instr_out, 32'h2008_000A);
        check("f0_hold_req", {31'd0, fetchBus.imem_req}, 32'd0);
        tick();
        check("f1_fetch_valid", {31'd0, fetchBus.instr_valid}, 32'd0);
        waitReq("f1");
        check("f1_addr", {19'd0, fetchBus.imem_addr}, 32'h0004);

        // Stall for 5 cycles with a jump pulse in the middle; the jump must be ignored.
        ackWith(32'h8C09_0004);
        fetchBus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                fetchBus.jump        = 1'b1;
                fetchBus.jump_target = 32'h0040_0100;
            end else begin
                fetchBus.jump = 1'b0;
            end
            tick();
        end
        fetchBus.jump = 1'b0;
        check("stall_valid", {31'd0, fetchBus.instr_valid}, 32'd1);
        check("stall_instr", fetchBus.instr_out, 32'h8C09_0004);
        check("stall_pcout", fetchBus.pc_out, 32'h0040_0004);
        check("stall_req",   {31'd0, fetchBus.imem_req}, 32'd0);
        fetchBus.stall = 1'b0;
        tick();
        waitReq("seq2");
        check("seq2_addr", {19'd0, fetchBus.imem_addr}, 32'h0008);

        // Jump and branch together: jump wins.
        ackWith(32'h0000_0000);
        fetchBus.jump          = 1'b1;
        fetchBus.jump_target   = 32'h0040_0100;
        fetchBus.branch_taken  = 1'b1;
        fetchBus.branch_target = 32'h0040_0040;
        tick();
        fetchBus.jump         = 1'b0;
        fetchBus.branch_taken = 1'b0;
        waitReq("jmp");
        check("jmp_addr", {19'd0, fetchBus.imem_addr}, 32'h0100);

        // Branch to the last word of the window, then step off the end.
        ackWith(32'h1111_1111);
        check("jmp_pcout", fetchBus.pc_out, 32'h0040_0100);
        fetchBus.branch_taken  = 1'b1;
        fetchBus.branch_target = 32'h0040_1FFC;
        tick();
        fetchBus.branch_taken = 1'b0;
        waitReq("top");
        check("top_addr", {19'd0, fetchBus.imem_addr}, 32'h1FFC);
        ackWith(32'h2222_2222);
        check("top_valid", {31'd0, fetchBus.instr_valid}, 32'd1);
        check("top_pcout", fetchBus.pc_out, 32'h0040_1FFC);
        tick();   // HOLD -> FETCH at 0x00402000
        check("past_fetch_req", {31'd0, fetchBus.imem_req}, 32'd0);
        tick();   // FETCH -> FAULT
        check("past_inv",     {31'd0, fetchBus.invalid_pc}, 32'd1);
        check("past_faultpc", fetchBus.fault_pc, 32'h0040_2000);
        check("past_tmo",     {31'd0, fetchBus.fetch_timeout}, 32'd0);
        check("past_valid",   {31'd0, fetchBus.instr_valid}, 32'd0);
        fetchBus.imem_ack = 1'b1;
        fetchBus.stall    = 1'b0;
        tick();
        tick();
        fetchBus.imem_ack = 1'b0;
        check("past_sticky_req", {31'd0, fetchBus.imem_req}, 32'd0);
        check("past_sticky_inv", {31'd0, fetchBus.invalid_pc}, 32'd1);

        // Asynchronous reset clears the sticky fault without a clock edge.
        rst = 1'b1;
        #1;
        check("arst_inv",     {31'd0, fetchBus.invalid_pc}, 32'd0);
        check("arst_faultpc", fetchBus.fault_pc, 32'd0);
        tick();
        rst = 1'b0;

        // Misaligned branch target faults without any request.
        tick();
        waitReq("mis0");
        ackWith(32'h3333_3333);
        fetchBus.branch_taken  = 1'b1;
        fetchBus.branch_target = 32'h0040_0002;
        tick();
        fetchBus.branch_taken = 1'b0;
        check("mis_fetch_req", {31'd0, fetchBus.imem_req}, 32'd0);
        tick();
        check("mis_req",     {31'd0, fetchBus.imem_req}, 32'd0);
        check("mis_inv",     {31'd0, fetchBus.invalid_pc}, 32'd1);
        check("mis_faultpc", fetchBus.fault_pc, 32'h0040_0002);
        for (int i = 0; i < 3; i++) tick();
        check("mis_sticky_inv",     {31'd0, fetchBus.invalid_pc}, 32'd1);
        check("mis_sticky_faultpc", fetchBus.fault_pc, 32'h0040_0002);
        check("mis_sticky_req",     {31'd0, fetchBus.imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        check("mis_rst_inv",     {31'd0, fetchBus.invalid_pc}, 32'd0);
        check("mis_rst_faultpc", fetchBus.fault_pc, 32'd0);

        // No ack at all: timeout after 16 WAIT cycles.
        rst = 1'b0;
        tick();   // WAIT cycle 1
        for (int i = 0; i < 15; i++) tick();   // WAIT cycle 16
        check("tmo_last_req", {31'd0, fetchBus.imem_req}, 32'd1);
        check("tmo_last_flag", {31'd0, fetchBus.fetch_timeout}, 32'd0);
        tick();
        check("tmo_flag",    {31'd0, fetchBus.fetch_timeout}, 32'd1);
        check("tmo_faultpc", fetchBus.fault_pc, 32'h0040_0000);
        check("tmo_req",     {31'd0, fetchBus.imem_req}, 32'd0);
        check("tmo_inv",     {31'd0, fetchBus.invalid_pc}, 32'd0);

        // Ack on the 16th WAIT cycle beats the timeout.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();   // WAIT cycle 1
        for (int i = 0; i < 15; i++) tick();   // WAIT cycle 16
        ackWith(32'h4444_4444);
        check("late_ack_tmo",   {31'd0, fetchBus.fetch_timeout}, 32'd0);
        check("late_ack_valid", {31'd0, fetchBus.instr_valid}, 32'd1);
        check("late_ack_instr", fetchBus.instr_out, 32'h4444_4444);

        // Reset mid-WAIT; an ack arriving after reset is ignored in FETCH.
        fetchBus.stall = 1'b0;
        tick();
        tick();
        check("abort_req", {31'd0, fetchBus.imem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_rst_req", {31'd0, fetchBus.imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        fetchBus.imem_ack   = 1'b1;
        fetchBus.imem_rdata = 32'h5555_5555;
        tick();
        fetchBus.imem_ack = 1'b0;
        check("abort_valid", {31'd0, fetchBus.instr_valid}, 32'd0);
        check("abort_instr", fetchBus.instr_out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
